// File: rtl/sd_cmd_pkg.sv
// Shared constants and state type for the SD command-line serializer.
// Frame geometry and CRC7 polynomial live here so RTL and tooling agree.
package sd_cmd_pkg;

    localparam int FRAME_BITS = 48;
    localparam int DATA_BITS  = 40;
    localparam int CRC_BITS   = 7;
    localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, init 0), one bit per cycle when en is high.
// Result is registered; clr has priority over en.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                bit_in,
    output logic [CRC_BITS-1:0] crc
);

    logic fb;
    assign fb = crc[CRC_BITS-1] ^ bit_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
        end
    end

endmodule

// File: rtl/sd_cmd_serializer.sv
// Serializes a 48-bit SD command frame onto CMD, one bit per clk_en, then idles GAP_BITS periods.
// Outputs registered; start is ignored while ready is low.
module sd_cmd_serializer
    import sd_cmd_pkg::*;
#(
    parameter int GAP_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        ready,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic        done
);

    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam int SW = DATA_BITS - 1;

    state_t         state;
    logic [5:0]     bit_cnt;
    logic [GW-1:0]  gap_cnt;
    logic [SW-1:0]  shreg;
    logic [CRC_BITS-1:0] crc;
    logic           accept;
    logic           crc_en;

    assign accept = (state == IDLE) && start && ready;
    // The start bit is 0 and the CRC starts at 0, so feeding it would be a no-op;
    // the CRC instead absorbs each bit as it is launched, ready just in time for bit 40.
    assign crc_en = (state == SHIFT) && clk_en && (bit_cnt < 6'(DATA_BITS - 1));

    sd_crc7 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (crc_en),
        .bit_in (shreg[SW-1]),
        .crc    (crc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
            cmd_out <= 1'b1;
            cmd_oe  <= 1'b0;
            ready   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (accept) begin
                        state   <= SHIFT;
                        ready   <= 1'b0;
                        bit_cnt <= '0;
                        shreg   <= {1'b1, cmd_index, cmd_arg};
                        cmd_oe  <= 1'b1;
                        cmd_out <= 1'b0;
                    end
                end
                SHIFT: if (clk_en) begin
                    if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                        cmd_oe  <= 1'b0;
                        cmd_out <= 1'b1;
                        gap_cnt <= '0;
                        if (GAP_BITS == 0) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            ready <= 1'b1;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'(DATA_BITS - 1)) begin
                            // Reload with CRC bits followed by the end bit.
                            cmd_out <= crc[CRC_BITS-1];
                            shreg   <= {crc[CRC_BITS-2:0], 1'b1, {(SW - CRC_BITS){1'b0}}};
                        end else begin
                            cmd_out <= shreg[SW-1];
                            shreg   <= {shreg[SW-2:0], 1'b0};
                        end
                    end
                end
                GAP: if (clk_en) begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/sd_cmd_serializer.md
SD_CMD_SERIALIZER -- requirements
Module: sd_cmd_serializer

Interface
REQ-001 Parameter GAP_BITS, default 8: number of clk_en periods the line is released after the end bit, giving N_CC spacing.
REQ-002 Clock/reset: one clock; reset is asynchronous and active-high. Ports: clk input 1, system clock; rst input 1, asynchronous active-high reset.
REQ-003 clk_en  input  1  SD bit strobe, one-clk pulse per SD clock period.
REQ-004 start  input  1  command request, qualified by ready.
REQ-005 cmd_index  input  6  command index, sampled at acceptance.
REQ-006 cmd_arg  input  32  command argument, sampled at acceptance.
REQ-007 ready  output  1  high when idle and able to accept start.
REQ-008 cmd_out  output  1  serial CMD line data, to the output delay stage.
REQ-009 cmd_oe  output  1  CMD line drive enable, to the output delay stage.
REQ-010 done  output  1  one-clk pulse when the frame and the gap are both complete.

Function
REQ-011 Acceptance SHALL occur on the clk edge where start=1 and ready=1; cmd_index/cmd_arg SHALL be captured then, and start SHALL be ignored while ready=0.
REQ-012 Frame SHALL be 48 bits, MSB first: start bit 0, transmission bit 1, cmd_index[5:0], cmd_arg[31:0], CRC7[6:0], end bit 1.
REQ-013 CRC7 SHALL use polynomial x^7+x^3+1 with initial value 0, computed serially over frame bits 0..39.
REQ-014 FSM states: IDLE, SHIFT, GAP. IDLE->SHIFT on acceptance; SHIFT->GAP on the clk_en that ends bit 47; GAP->IDLE on the GAP_BITS-th clk_en in GAP.
REQ-015 At acceptance, the registered outputs SHALL become cmd_oe=1 and cmd_out=0 (start bit), visible the next clk cycle.
REQ-016 In SHIFT, each clk_en pulse SHALL advance exactly one bit; cmd_out SHALL stay constant between pulses.
REQ-017 A clk_en coincident with the acceptance edge SHALL NOT advance the frame, so the start bit lasts at least one full clk_en period.
REQ-018 In GAP and IDLE, outputs SHALL be cmd_oe=0 and cmd_out=1.
REQ-019 done SHALL pulse for 1 clk on the GAP->IDLE transition; ready SHALL rise on the same edge.
REQ-020 ready SHALL be 0 throughout SHIFT and GAP.
REQ-021 The bit counter SHALL be 6 bits (0..47) and the gap counter SHALL be wide enough for GAP_BITS; neither counter SHALL wrap within a frame.
REQ-022 GAP_BITS=0 SHALL go SHIFT->IDLE directly, with done on that edge.

Reset
REQ-023 While rst=1: state=IDLE, cmd_oe=0, cmd_out=1, ready=0, done=0, and counters and CRC cleared.
REQ-024 ready SHALL rise on the first clk edge after rst deasserts.
REQ-025 rst asserted mid-frame SHALL release the line (cmd_oe=0) asynchronously, with no done pulse.

Structure
REQ-026 The shared package sd_cmd_pkg SHALL hold: FRAME_BITS=48, CRC_BITS=7, CRC7_POLY=7'h09, and the state enum.
REQ-027 Sub-module sd_crc7: serial CRC7 with clear, enable and bit inputs and a 7-bit crc output, instantiated once.
REQ-028 All outputs SHALL be registered.

Verification
REQ-029 CMD0, arg 0x00000000, clk_en every 4 clk -> line bits 0x400000000095, cmd_oe high for exactly 48 periods, then done after 8 gap periods.
REQ-030 CMD8, arg 0x000001AA -> frame 0x48000001AA87 (CRC7=0x43).
REQ-031 CMD17, arg 0, with start asserted again mid-frame -> frame 0x510000000055; the second start is ignored and only one done is produced.
REQ-032 clk_en coincident with acceptance -> the start bit is held until the following clk_en, and the frame is still exactly 48 bits.
REQ-033 rst pulsed at bit 20 -> cmd_oe=0 and cmd_out=1 without waiting for clk, no done, ready=1 one clk after release, and the next command is sent correctly.
REQ-034 GAP_BITS=0 build, back-to-back commands -> second frame starts on the clk after done, with no line gap beyond one bit period.
